// File: rtl/rv_core_pkg.sv
// Shared core types and widths for the front end.
package rv_core_pkg;

    localparam int XLEN     = 32;
    localparam int IF_DEPTH = 2;

    // One in-flight fetch: its word address and whether a flush has orphaned it.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            stale;
    } pend_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: PC handshake, instruction memory request/response, decode handoff.
interface instruction_fetch_if #(
    parameter int XLEN = rv_core_pkg::XLEN
) ();
    import rv_core_pkg::*;

    logic [XLEN-1:0] fetch_pc;
    logic            pc_hold;
    logic            flush;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    // master = the fetch unit, slave = PC stage, memory and decode around it
    modport master (
        input  fetch_pc, flush,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output pc_hold, imem_req_valid, imem_addr,
        output inst_valid, inst_data, inst_pc
    );

    modport slave (
        output fetch_pc, flush,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  pc_hold, imem_req_valid, imem_addr,
        input  inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous clear; head word is visible combinationally.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Credit-limited instruction fetch: tracks in-flight addresses, drops orphaned responses on flush.
module instruction_fetch
    import rv_core_pkg::*;
#(
    parameter int DEPTH = IF_DEPTH,
    parameter int XLEN  = rv_core_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instruction_fetch_if.master  bus
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    pend_entry_t         pend_q [DEPTH];
    pend_entry_t         pend_head;
    logic [AW-1:0]       pend_wr;
    logic [AW-1:0]       pend_rd;
    logic [CW-1:0]       pend_cnt;

    logic [CW-1:0]       iq_cnt;
    logic                iq_full;
    logic                iq_empty;
    logic                iq_push;
    logic                iq_pop;
    logic [2*XLEN-1:0]   iq_wdata;
    logic [2*XLEN-1:0]   iq_rdata;

    logic [CW:0]         occ;
    logic                accept;
    logic                rsp_pop;

    // An instruction leaving to decode this cycle already frees its credit,
    // which keeps a single-cycle memory streaming at one fetch per clock.
    assign iq_pop = ~iq_empty & bus.inst_ready;
    assign occ    = {1'b0, pend_cnt} + {1'b0, iq_cnt} - {{CW{1'b0}}, iq_pop};

    assign bus.imem_req_valid = reset_n & ~bus.flush & (occ < DEPTH_C);
    assign bus.imem_addr      = bus.fetch_pc;
    assign accept             = bus.imem_req_valid & bus.imem_req_ready;
    assign bus.pc_hold        = ~accept;

    assign pend_head = pend_q[pend_rd];
    assign rsp_pop   = bus.imem_rsp_valid & (pend_cnt != '0);
    assign iq_push   = rsp_pop & ~pend_head.stale & ~bus.flush;
    assign iq_wdata  = {pend_head.addr, bus.imem_rsp_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_wr  <= '0;
            pend_rd  <= '0;
            pend_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) pend_q[i] <= '0;
        end else begin
            if (accept) begin
                pend_q[pend_wr] <= '{addr: bus.fetch_pc, stale: 1'b0};
                pend_wr         <= pend_wr + AW'(1);
            end
            if (rsp_pop) pend_rd <= pend_rd + AW'(1);
            pend_cnt <= pend_cnt + CW'(accept) - CW'(rsp_pop);
            // No request is accepted during flush, so marking every slot is safe:
            // empty slots get a fresh stale=0 when next written.
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) pend_q[i].stale <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_iq (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.flush),
        .push    (iq_push),
        .wdata   (iq_wdata),
        .pop     (iq_pop),
        .rdata   (iq_rdata),
        .full    (iq_full),
        .empty   (iq_empty),
        .count   (iq_cnt)
    );

    assign bus.inst_valid = ~iq_empty;
    assign {bus.inst_pc, bus.inst_data} = iq_empty ? '0 : iq_rdata;

    a_rsp_has_pending: assert property (
        @(posedge clk) disable iff (!reset_n) bus.imem_rsp_valid |-> (pend_cnt != '0)
    );

    a_iq_no_overflow: assert property (
        @(posedge clk) disable iff (!reset_n) iq_push |-> (!iq_full || iq_pop)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fixed-latency memory and a simple PC stage.
module tb_instruction_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instruction_fetch_if #(.XLEN(32)) bus ();

    instruction_fetch #(.DEPTH(2), .XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // PC stage: advances on accept, loads the redirect target on flush.
    logic [31:0] pc;
    logic [31:0] flush_tgt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)             pc <= '0;
        else if (bus.flush)       pc <= flush_tgt;
        else if (!bus.pc_hold)    pc <= pc + 1;
    end
    assign bus.fetch_pc = pc;

    // Memory: fixed latency lat (1..4) cycles, data = addr ^ KEY, reset with the core.
    int          lat;
    logic        mv [4];
    logic [31:0] ma [4];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin mv[k] <= 1'b0; ma[k] <= '0; end
        end else begin
            mv[0] <= bus.imem_req_valid & bus.imem_req_ready;
            ma[0] <= bus.imem_addr;
            for (int k = 1; k < 4; k++) begin mv[k] <= mv[k-1]; ma[k] <= ma[k-1]; end
        end
    end
    assign bus.imem_rsp_valid = mv[lat-1];
    assign bus.imem_rsp_data  = ma[lat-1] ^ KEY;

    // Monitor: samples mid-cycle after stimulus settles; sole writer of these.
    logic [31:0] got [$];
    int          acc_cnt  = 0;
    int          data_bad = 0;
    always begin
        @(negedge clk);
        #3;
        if (reset_n) begin
            if (bus.inst_valid && bus.inst_ready) begin
                got.push_back(bus.inst_pc);
                if (bus.inst_data !== (bus.inst_pc ^ KEY)) data_bad++;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) acc_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge that starts cycle 0 after release.
    task automatic do_reset(input int new_lat);
        reset_n = 1'b0;
        lat     = new_lat;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, a0, bad, hold_bad, dep_bad, stalls;
        logic v0;

        reset_n = 1'b0;
        lat = 1;
        flush_tgt = '0;
        bus.flush = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;

        // Reset values
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_pc_hold", bus.pc_hold, 1);
        chk("rst_inst_data", bus.inst_data, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);

        // Zero-wait stream: first request cycle 0, inst_pc 0..3 in cycles 2..5
        @(negedge clk);
        do_reset(1);
        #1;
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_req_addr", bus.imem_addr, 0);
        chk("first_pc_hold", bus.pc_hold, 0);
        @(negedge clk); #1;
        chk("lat_c1_valid", bus.inst_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("stream_valid_%0d", k), bus.inst_valid, 1);
            chk($sformatf("stream_pc_%0d", k), bus.inst_pc, k);
            chk($sformatf("stream_data_%0d", k), bus.inst_data, 32'(k) ^ KEY);
        end

        // Decode stalled 10 cycles: exactly two requests, head held
        @(negedge clk);
        bus.inst_ready = 1'b0;
        do_reset(1);
        a0 = acc_cnt; b0 = got.size(); bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c >= 2 && (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd0 || bus.inst_data !== KEY)) bad++;
            @(negedge clk);
        end
        #1;
        chk("stall_pc_hold", bus.pc_hold, 1);
        chk("stall_inst_pc", bus.inst_pc, 0);
        chk("stall_stable", bad, 0);
        chk("stall_req_count", acc_cnt - a0, 2);
        bus.inst_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("release_0", got[b0], 0);
        chk("release_1", got[b0+1], 1);
        chk("release_2", got[b0+2], 2);

        // Flush with two outstanding, latency 3
        @(negedge clk);
        do_reset(3);
        repeat (2) @(negedge clk);
        flush_tgt = 32'd100;
        bus.flush = 1'b1;
        b0 = got.size();
        #1;
        chk("flush2_req_valid", bus.imem_req_valid, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("stale_credit_c3", bus.imem_req_valid, 0);
        @(negedge clk); #1;
        chk("resume_req_valid", bus.imem_req_valid, 1);
        chk("resume_addr", bus.imem_addr, 100);
        repeat (4) @(negedge clk); #1;
        chk("flush2_valid_c8", bus.inst_valid, 1);
        chk("flush2_pc_c8", bus.inst_pc, 100);
        @(negedge clk); #1;
        chk("flush2_pc_c9", bus.inst_pc, 101);
        chk("flush2_first_got", got[b0], 100);

        // Flush coinciding with a response and a decode pop
        @(negedge clk);
        do_reset(1);
        repeat (4) @(negedge clk);
        flush_tgt = 32'd200;
        bus.flush = 1'b1;
        #1;
        chk("flushc_req_gated", bus.imem_req_valid, 0);
        chk("flushc_pop_valid", bus.inst_valid, 1);
        chk("flushc_rsp_present", bus.imem_rsp_valid, 1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flushc_empty_c5", bus.inst_valid, 0);
        @(negedge clk); #1;
        chk("flushc_empty_c6", bus.inst_valid, 0);
        @(negedge clk); #1;
        chk("flushc_valid_c7", bus.inst_valid, 1);
        chk("flushc_pc_c7", bus.inst_pc, 200);

        // Memory randomly not ready
        @(negedge clk);
        do_reset(1);
        b0 = got.size(); hold_bad = 0; dep_bad = 0; stalls = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            bus.imem_req_ready = 1'b0;
            #1;
            v0 = bus.imem_req_valid;
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            #1;
            if (v0 !== bus.imem_req_valid) dep_bad++;
            if (bus.pc_hold !== ~(bus.imem_req_valid & bus.imem_req_ready)) hold_bad++;
            if (!bus.imem_req_ready) stalls++;
        end
        bus.imem_req_ready = 1'b1;
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = b0; i < got.size(); i++) if (got[i] !== 32'(i - b0)) bad++;
        chk("rand_req_indep", dep_bad, 0);
        chk("rand_pc_hold", hold_bad, 0);
        chk("rand_stalls_seen", stalls > 0, 1);
        chk("rand_seq", bad, 0);
        chk("rand_count", (got.size() - b0) >= 20, 1);

        // Reset asserted with two in flight
        @(negedge clk);
        do_reset(3);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", bus.imem_req_valid, 0);
        chk("mid_rst_inst_valid", bus.inst_valid, 0);
        chk("mid_rst_pc_hold", bus.pc_hold, 1);
        chk("mid_rst_inst_data", bus.inst_data, 0);
        chk("mid_rst_inst_pc", bus.inst_pc, 0);
        repeat (2) @(negedge clk);
        lat = 1;
        reset_n = 1'b1;
        b0 = got.size();
        repeat (3) @(negedge clk); #1;
        chk("post_rst_first", got[b0], 0);
        chk("post_rst_pc_c3", bus.inst_pc, 1);

        chk("data_integrity", data_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DEPTH, default 2, meaning maximum instructions in flight plus buffered; power of two, at least 2.
REQ-002 Parameter XLEN, default 32, meaning address and instruction width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_pc  input  XLEN  word address from program counter stage.
REQ-006 pc_hold  output  1  high = program counter must not advance this cycle.
REQ-007 flush  input  1  redirect pulse; discards everything in flight and buffered.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_addr  output  XLEN  request word address.
REQ-011 imem_rsp_valid  input  1  in-order response valid; no backpressure.
REQ-012 imem_rsp_data  input  XLEN  instruction word.
REQ-013 inst_valid  output  1  instruction available to decode.
REQ-014 inst_ready  input  1  decode accepts instruction.
REQ-015 inst_data / inst_pc  output  XLEN each  instruction and its word address.

Function
REQ-016 Credit rule: imem_req_valid SHALL be high only when (outstanding + buffered) < DEPTH and flush is low; it SHALL NOT depend on imem_req_ready.
REQ-017 imem_addr SHALL equal fetch_pc combinationally.
REQ-018 Request accepted when imem_req_valid and imem_req_ready; pc_hold SHALL equal NOT(accept), so the PC advances exactly once per accepted request.
REQ-019 On accept, fetch_pc SHALL be pushed into a pending-address queue of DEPTH entries, each with a stale bit initialised to 0.
REQ-020 On imem_rsp_valid, the oldest pending entry SHALL be popped; if not stale, {address, data} SHALL be pushed into the instruction queue; if stale, the response SHALL be dropped.
REQ-021 Latency: a response in cycle N SHALL appear on inst_valid/inst_data/inst_pc in cycle N+1 at the earliest (registered queue, no bypass).
REQ-022 inst_valid SHALL equal instruction queue non-empty; the queue pops on inst_valid and inst_ready; push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-023 Outputs SHALL remain stable while inst_valid is high and inst_ready is low.
REQ-024 Flush in cycle N: instruction queue emptied; every pending entry present after cycle N's accept/response updates marked stale; no request issued in cycle N; a response arriving in cycle N is dropped.
REQ-025 After flush, requests resume in cycle N+1 subject to credit; stale entries still consume credit until their responses return.
REQ-026 A response with no pending entry is a protocol violation; behaviour is undefined, and an assertion SHALL flag it.
REQ-027 Pointers wrap modulo DEPTH; occupancy counters are clog2(DEPTH)+1 bits wide.

Reset
REQ-028 While reset_n is low: both queues empty, all stale bits 0, imem_req_valid=0, inst_valid=0, pc_hold=1, inst_data=0, inst_pc=0.
REQ-029 Reset asserted mid-operation SHALL abandon all in-flight requests immediately; the memory is reset from the same reset_n.
REQ-030 The first request SHALL be issued in the first cycle after reset_n deasserts, with fetch_pc=0.

Structure
REQ-031 Shared package rv_core_pkg SHALL hold XLEN, the default DEPTH and the pending-entry struct (address plus stale bit).
REQ-032 One generic sub-module, sync_fifo (parameterised width and depth, full/empty/count), SHALL be instantiated for the instruction queue; the pending queue is local because it needs per-entry stale access.

Verification
REQ-033 Zero-wait memory, inst_ready=1: PCs 0,1,2,3 fetched -> inst_pc 0,1,2,3 in consecutive cycles from cycle 2 after reset.
REQ-034 inst_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued, pc_hold=1 thereafter, inst_pc=0 held stable; release -> 0,1,2 in order, no loss or duplicates.
REQ-035 Flush with 2 outstanding (responses return 3 cycles later) -> both dropped; next inst_pc equals fetch_pc presented at flush+1.
REQ-036 Flush coinciding with a response and a queue pop -> queue empty next cycle, inst_valid=0.
REQ-037 imem_req_ready randomly low 50% -> pc_hold mirrors non-acceptance; output PC sequence contiguous.
REQ-038 reset_n asserted with 2 in flight -> all outputs at reset values same cycle; post-reset stream restarts at inst_pc=0.
